seg7_scan_driver: RTL and testbench

//  Parametrised seven-segment display engine for the watch/stopwatch designs. Takes NUM_FIELDS binary

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_scan_driver_bin2bcd.sv | 54 +++++
 rtl/seg7_scan_driver.sv | 176 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and BCD-to-segment encoder for the display engine.
// Segment patterns are internal active-low, bit0 = a .. bit6 = g.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_COMMIT
   } state_t;

   function automatic logic [6:0] seg7_encode(input logic [3:0] bcd);
      case (bcd)
         4'd0:    seg7_encode = 7'b1000000;
         4'd1:    seg7_encode = 7'b1111001;
         4'd2:    seg7_encode = 7'b0100100;
         4'd3:    seg7_encode = 7'b0110000;
         4'd4:    seg7_encode = 7'b0011001;
         4'd5:    seg7_encode = 7'b0010010;
         4'd6:    seg7_encode = 7'b0000010;
         4'd7:    seg7_encode = 7'b1111000;
         4'd8:    seg7_encode = 7'b0000000;
         4'd9:    seg7_encode = 7'b0010000;
         default: seg7_encode = SEG_BLANK;
      endcase
   endfunction

   function automatic longint unsigned pow10(input int n);
      pow10 = 1;
      for (int i = 0; i < n; i++) pow10 = pow10 * 10;
   endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd.sv
// Sequential double-dabble: one add-3-then-shift step per clock, FIELD_W steps per conversion.
// Carries one spare BCD digit internally; only the low DIGITS digits are presented.
module bin2bcd_seq #(
   parameter int FIELD_W = 7,
   parameter int DIGITS  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [FIELD_W-1:0]    value,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int NDIG  = DIGITS + 1;
   localparam int CNT_W = $clog2(FIELD_W + 1);

   logic [FIELD_W-1:0]         bin_q;
   logic [4*NDIG-1:0]          bcd_q;
   logic [4*NDIG-1:0]          bcd_adj;
   logic [4*NDIG+FIELD_W-1:0]  shifted;
   logic [CNT_W-1:0]           cnt_q;

   // NOTE: combinational outputs get a full default before any conditional update, so no latch is inferred.
   always_comb begin
      bcd_adj = bcd_q;
      for (int d = 0; d < NDIG; d++) begin
         if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      end
      shifted = {bcd_adj, bin_q} << 1;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bin_q <= '0;
         bcd_q <= '0;
         cnt_q <= '0;
      end else if (start) begin
         bin_q <= value;
         bcd_q <= '0;
         cnt_q <= CNT_W'(FIELD_W);
      end else if (cnt_q != '0) begin
         {bcd_q, bin_q} <= shifted;
         cnt_q          <= cnt_q - 1'b1;
      end
   end

   assign busy = (cnt_q != '0);
   assign done = (cnt_q == CNT_W'(1));
   assign bcd  = bcd_q[4*DIGITS-1:0];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multi-field seven-segment engine: converts all fields, commits them at once, then drives
// static per-digit patterns plus a time-multiplexed scan bus with blanking, blink and overflow dashes.
module seg7_scan_driver #(
   parameter int NUM_FIELDS  = 4,
   parameter int FIELD_W     = 7,
   parameter int DIGITS      = 2,
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 25000000,
   parameter bit ACTIVE_LOW  = 1'b1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             upd_valid,
   output logic                             upd_ready,
   input  logic [NUM_FIELDS*FIELD_W-1:0]    field_value,
   input  logic [NUM_FIELDS-1:0]            lz_blank_en,
   input  logic [NUM_FIELDS-1:0]            blink_en,
   output logic [NUM_FIELDS*DIGITS*7-1:0]   seg_static,
   output logic [6:0]                       seg_scan,
   output logic [NUM_FIELDS*DIGITS-1:0]     an_scan,
   output logic [NUM_FIELDS-1:0]            overflow
);

   import seg7_pkg::*;

   localparam int TOT_DIG = NUM_FIELDS * DIGITS;
   localparam int IDX_W   = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
   localparam int SCAN_W  = (TOT_DIG > 1) ? $clog2(TOT_DIG) : 1;
   localparam int REF_W   = $clog2(REFRESH_DIV + 1);
   localparam int BLK_W   = $clog2(BLINK_DIV + 1);
   localparam longint unsigned LIMIT = pow10(DIGITS);

   state_t state_q, state_d;
   logic   conv_start, conv_busy, conv_done, commit, capture;

   logic [IDX_W-1:0]                        field_q;
   logic [NUM_FIELDS*FIELD_W-1:0]           cap_q;
   logic [FIELD_W-1:0]                      cur_value;
   logic [4*DIGITS-1:0]                     conv_bcd;
   logic [NUM_FIELDS-1:0][DIGITS-1:0][3:0]  stage_q, stage_merged, bank_q;
   logic [NUM_FIELDS-1:0]                   ovf_stage_q, ovf_q;

   logic [TOT_DIG-1:0][6:0]  pat;
   logic [6:0]               p;
   logic                     upper_zero;

   logic [REF_W-1:0]   ref_q;
   logic [SCAN_W-1:0]  idx_q, idx_d;
   logic               ref_wrap;
   logic [TOT_DIG-1:0] an_q;
   logic [6:0]         scan_q;
   logic [BLK_W-1:0]   blk_q;
   logic               blk_wrap, blink_phase_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (upd_valid) state_d = ST_LOAD;
         ST_LOAD:   state_d = ST_SHIFT;
         ST_SHIFT:  if (conv_done)
                       state_d = (field_q == IDX_W'(NUM_FIELDS-1)) ? ST_COMMIT : ST_LOAD;
         ST_COMMIT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      upd_ready  = (state_q == ST_IDLE);
      capture    = upd_ready && upd_valid;
      conv_start = (state_q == ST_LOAD) && !conv_busy;
      commit     = (state_q == ST_COMMIT);
   end

   assign cur_value = cap_q[field_q*FIELD_W +: FIELD_W];

   bin2bcd_seq #(
      .FIELD_W (FIELD_W),
      .DIGITS  (DIGITS)
   ) u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .value (cur_value),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // The converter result of the field just finished is valid during the following LOAD or COMMIT.
   always_comb begin
      stage_merged = stage_q;
      if (state_q == ST_COMMIT)
         stage_merged[field_q] = conv_bcd;
      else if (state_q == ST_LOAD && field_q != '0)
         stage_merged[field_q - 1'b1] = conv_bcd;
   end

   // NOTE: the digit bank is a small set of flops, not a RAM, so it takes the async reset like other state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cap_q       <= '0;
         field_q     <= '0;
         stage_q     <= '0;
         ovf_stage_q <= '0;
         bank_q      <= '0;
         ovf_q       <= '0;
      end else begin
         if (capture) begin
            cap_q   <= field_value;
            field_q <= '0;
         end else if (state_q == ST_SHIFT && conv_done && field_q != IDX_W'(NUM_FIELDS-1)) begin
            field_q <= field_q + 1'b1;
         end
         if (conv_start) ovf_stage_q[field_q] <= (64'(cur_value) >= LIMIT);
         stage_q <= stage_merged;
         if (commit) begin
            bank_q <= stage_merged;
            ovf_q  <= ovf_stage_q;
         end
      end
   end

   always_comb begin
      pat        = '0;
      p          = SEG_BLANK;
      upper_zero = 1'b1;
      for (int k = 0; k < NUM_FIELDS; k++) begin
         upper_zero = 1'b1;
         for (int j = DIGITS - 1; j >= 0; j--) begin
            upper_zero = upper_zero && (bank_q[k][j] == 4'd0);
            p = seg7_encode(bank_q[k][j]);
            if (ovf_q[k])                                   p = SEG_DASH;
            else if (lz_blank_en[k] && j != 0 && upper_zero) p = SEG_BLANK;
            if (blink_en[k] && blink_phase_q)                p = SEG_BLANK;
            pat[k*DIGITS + j] = p;
         end
      end
   end

   always_comb begin
      ref_wrap = (ref_q == REF_W'(REFRESH_DIV - 1));
      blk_wrap = (blk_q == BLK_W'(BLINK_DIV - 1));
      idx_d    = idx_q;
      if (ref_wrap) idx_d = (idx_q == SCAN_W'(TOT_DIG - 1)) ? '0 : idx_q + 1'b1;
   end

   // Scan outputs load from the next index so they move on the same edge as the index itself.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ref_q         <= '0;
         idx_q         <= '0;
         an_q          <= TOT_DIG'(1);
         scan_q        <= SEG_BLANK;
         blk_q         <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         ref_q  <= ref_wrap ? '0 : ref_q + 1'b1;
         idx_q  <= idx_d;
         an_q   <= TOT_DIG'(1) << idx_d;
         scan_q <= pat[idx_d];
         blk_q  <= blk_wrap ? '0 : blk_q + 1'b1;
         if (blk_wrap) blink_phase_q <= ~blink_phase_q;
      end
   end

   assign seg_static = ACTIVE_LOW ? pat    : ~pat;
   assign seg_scan   = ACTIVE_LOW ? scan_q : ~scan_q;
   assign an_scan    = ACTIVE_LOW ? ~an_q  : an_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: a decimal-level display model is compared every cycle, plus directed literal checks.
module tb_seg7_scan_driver;

   localparam int NF   = 4;
   localparam int FW   = 7;
   localparam int DG   = 2;
   localparam int TOT  = NF * DG;
   localparam int REF  = 4;
   localparam int BLK  = 16;
   localparam int BUSY = NF * (FW + 1) + 1;

   localparam logic [6:0] ENC [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                       7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
   localparam logic [6:0] BLANK = 7'b1111111;
   localparam logic [6:0] DASH  = 7'b0111111;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              upd_valid = 1'b0;
   logic              upd_ready;
   logic [NF*FW-1:0]  field_value = '0;
   logic [NF-1:0]     lz_blank_en = '0;
   logic [NF-1:0]     blink_en = '0;
   logic [TOT*7-1:0]  seg_static;
   logic [6:0]        seg_scan;
   logic [TOT-1:0]    an_scan;
   logic [NF-1:0]     overflow;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_FIELDS  (NF),
      .FIELD_W     (FW),
      .DIGITS      (DG),
      .REFRESH_DIV (REF),
      .BLINK_DIV   (BLK),
      .ACTIVE_LOW  (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .upd_valid   (upd_valid),
      .upd_ready   (upd_ready),
      .field_value (field_value),
      .lz_blank_en (lz_blank_en),
      .blink_en    (blink_en),
      .seg_static  (seg_static),
      .seg_scan    (seg_scan),
      .an_scan     (an_scan),
      .overflow    (overflow)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: edges since reset, remaining busy edges, and the decimal values currently on display.
   int unsigned n;
   int          busy_left;
   int unsigned pend [NF];
   int unsigned shown [NF];

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         n         <= 0;
         busy_left <= 0;
         for (int k = 0; k < NF; k++) shown[k] <= 0;
      end else begin
         n <= n + 1;
         if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) for (int k = 0; k < NF; k++) shown[k] <= pend[k];
         end else if (upd_valid) begin
            busy_left <= BUSY;
            for (int k = 0; k < NF; k++) pend[k] <= field_value[k*FW +: FW];
         end
      end
   end

   function automatic logic [6:0] exp_seg(input int k, input int j);
      int unsigned v, pw;
      logic [6:0]  s;
      v  = shown[k];
      pw = 1;
      for (int i = 0; i < j; i++) pw = pw * 10;
      if (v >= 100)                             s = DASH;
      else if (lz_blank_en[k] && j > 0 && v < pw) s = BLANK;
      else                                      s = ENC[(v / pw) % 10];
      if (blink_en[k] && ((n / BLK) % 2 == 1))  s = BLANK;
      return s;
   endfunction

   function automatic logic [6:0] dig(input int k, input int j);
      return seg_static[(k*DG + j)*7 +: 7];
   endfunction

   logic [TOT*7-1:0] es, prev_es;
   logic [TOT-1:0]   ea;
   logic [NF-1:0]    eo;
   bit               scan_ok = 1'b0;
   int               si;

   always @(negedge clk) begin
      for (int k = 0; k < NF; k++)
         for (int j = 0; j < DG; j++) es[(k*DG + j)*7 +: 7] = exp_seg(k, j);
      si = (n / REF) % TOT;
      ea = ~(TOT'(1) << si);
      for (int k = 0; k < NF; k++) eo[k] = (shown[k] >= 100);
      check("seg_static", seg_static, es);
      check("an_scan", an_scan, ea);
      check("overflow", overflow, eo);
      check("upd_ready", upd_ready, busy_left == 0);
      if (scan_ok && reset) check("seg_scan", seg_scan, prev_es[si*7 +: 7]);
      prev_es = es;
      scan_ok = reset;
   end

   function automatic logic [NF*FW-1:0] pack(input int sw, input int hr, input int mn, input int sc);
      return {FW'(sw), FW'(hr), FW'(mn), FW'(sc)};
   endfunction

   task automatic send(input logic [NF*FW-1:0] v, input bit poke, input string tag);
      int lows;
      @(posedge clk); #1;
      field_value = v;
      upd_valid   = 1'b1;
      @(posedge clk); #1;
      upd_valid = 1'b0;
      lows = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (upd_ready) break;
         lows++;
         if (poke && lows == 5) begin
            upd_valid   = 1'b1;
            field_value = '1;
         end
         if (poke && lows == 8) upd_valid = 1'b0;
      end
      check({tag, "_busy_cycles"}, lows, BUSY);
   endtask

   int blanks, steps;
   logic [TOT-1:0] last_an;

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset release defaults
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check("t1_seg_static", seg_static, {8{7'b1000000}});
      check("t1_an_scan", an_scan, 8'b11111110);
      check("t1_upd_ready", upd_ready, 1'b1);
      check("t1_overflow", overflow, 4'b0000);

      // 2: full update, with ignored upd_valid pulses while busy
      send(pack(99, 23, 59, 7), 1'b1, "t2");
      check("t2_sec_units", dig(0, 0), 7'b1111000);
      check("t2_sec_tens",  dig(0, 1), 7'b1000000);
      check("t2_min_units", dig(1, 0), 7'b0010000);
      check("t2_min_tens",  dig(1, 1), 7'b0010010);
      check("t2_hr_units",  dig(2, 0), 7'b0110000);
      check("t2_hr_tens",   dig(2, 1), 7'b0100100);
      check("t2_sw_units",  dig(3, 0), 7'b0010000);
      check("t2_sw_tens",   dig(3, 1), 7'b0010000);
      check("t2_overflow",  overflow, 4'b0000);

      // 3: overflow shows dashes, then clears
      send(pack(120, 23, 59, 7), 1'b0, "t3a");
      check("t3_overflow_set", overflow, 4'b1000);
      check("t3_sw_units_dash", dig(3, 0), DASH);
      check("t3_sw_tens_dash",  dig(3, 1), DASH);
      send(pack(5, 23, 59, 7), 1'b0, "t3b");
      check("t3_overflow_clr", overflow, 4'b0000);
      check("t3_sw_tens",  dig(3, 1), 7'b1000000);
      check("t3_sw_units", dig(3, 0), 7'b0010010);

      // 4: leading-zero blanking on minutes only
      @(posedge clk); #1 lz_blank_en = 4'b0010;
      send(pack(5, 23, 7, 7), 1'b0, "t4a");
      check("t4_min_tens_blank", dig(1, 1), BLANK);
      check("t4_min_units",      dig(1, 0), 7'b1111000);
      check("t4_sec_tens_kept",  dig(0, 1), 7'b1000000);
      send(pack(5, 23, 0, 7), 1'b0, "t4b");
      check("t4_zero_tens_blank", dig(1, 1), BLANK);
      check("t4_zero_units",      dig(1, 0), 7'b1000000);

      // 5: blink on hours, scan stepping
      @(posedge clk); #1;
      lz_blank_en = 4'b0000;
      blink_en    = 4'b0100;
      @(negedge clk);
      last_an = an_scan;
      blanks  = 0;
      steps   = 0;
      for (int c = 0; c < 32; c++) begin
         @(negedge clk);
         if (dig(2, 0) == BLANK) blanks++;
         if (an_scan != last_an) steps++;
         last_an = an_scan;
      end
      check("t5_blink_duty", blanks, 16);
      check("t5_scan_steps", steps, 8);
      repeat (40) @(posedge clk);

      // 6: reset in the middle of a conversion
      @(posedge clk); #1;
      field_value = pack(33, 44, 55, 66);
      upd_valid   = 1'b1;
      @(posedge clk); #1;
      upd_valid = 1'b0;
      repeat (9) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("t6_async_ready",  upd_ready, 1'b1);
      check("t6_async_an",     an_scan, 8'b11111110);
      check("t6_async_static", seg_static, {8{7'b1000000}});
      check("t6_async_ovf",    overflow, 4'b0000);
      @(posedge clk); #1 reset = 1'b1;
      for (int c = 0; c <= 40; c++) begin
         @(negedge clk);
         if (c == 0)  check("t6_an_c0", an_scan, 8'b11111110);
         if (c == 15) check("t6_hr_c15", dig(2, 0), 7'b1000000);
         if (c == 16) check("t6_hr_c16_blink", dig(2, 0), BLANK);
         if (c == 16) check("t6_an_c16", an_scan, 8'b11101111);
         if (c == 28) check("t6_an_c28", an_scan, 8'b01111111);
         if (c == 32) check("t6_an_c32_wrap", an_scan, 8'b11111110);
         if (c == 32) check("t6_hr_c32", dig(2, 0), 7'b1000000);
         if (c == 40) check("t6_sec_not_aborted", dig(0, 0), 7'b1000000);
         if (c == 40) check("t6_ready_after", upd_ready, 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
